// File: rtl/sr_trace_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr_trace_buf_if
//  Description : Bundle of the trace-buffer signals. The capture side
//                (clr/cap_en/pc/instr/a0) and the read side
//                (rd_ready/rd_valid/rd_*) are grouped here, together with the
//                status outputs (count/overflow/drop_cnt/cycle/timeout).
//  Modports    : master - producer/consumer that talks to the buffer
//                slave  - the trace buffer itself
//  Parameters  : DEPTH  - trace FIFO entries; sets the width of count
//  Revision    : 1.0 - initial release
// ============================================================================
interface sr_trace_buf_if #(
   parameter int DEPTH = 16
);
   localparam int c_cw = $clog2(DEPTH) + 1;

   // capture side
   logic              clr;
   logic              cap_en;
   logic [31:0]       pc;
   logic [31:0]       instr;
   logic [31:0]       a0;
   // read side
   logic              rd_ready;
   logic              rd_valid;
   logic [31:0]       rd_pc;
   logic [31:0]       rd_instr;
   logic [31:0]       rd_a0;
   // status
   logic [c_cw-1:0]   count;
   logic              overflow;
   logic [15:0]       drop_cnt;
   logic [15:0]       cycle;
   logic              timeout;

   modport master (
      output clr, cap_en, pc, instr, a0, rd_ready,
      input  rd_valid, rd_pc, rd_instr, rd_a0,
      input  count, overflow, drop_cnt, cycle, timeout
   );

   modport slave (
      input  clr, cap_en, pc, instr, a0, rd_ready,
      output rd_valid, rd_pc, rd_instr, rd_a0,
      output count, overflow, drop_cnt, cycle, timeout
   );
endinterface
`default_nettype wire

// File: rtl/sr_trace_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sr_trace_buf
//  Description : Execution trace buffer. Captures {pc, instr, a0} tuples into
//                a first-word-fall-through FIFO, counts dropped captures when
//                the FIFO is full, and stops capturing once a free-running
//                cycle counter reaches TIMEOUT. Draining continues after the
//                timeout.
//  Ports       : clk  - single clock, all state on its rising edge
//                rst  - asynchronous active-high reset
//                bus  - sr_trace_buf_if.slave:
//                       clr        synchronous clear (wins over push/pop)
//                       cap_en     capture request, pc/instr/a0 valid
//                       rd_ready   consumer accepts the head entry
//                       rd_valid   head entry available (count != 0)
//                       rd_pc/rd_instr/rd_a0  head entry fields
//                       count      occupancy, $clog2(DEPTH)+1 bits
//                       overflow   sticky, a capture was dropped
//                       drop_cnt   dropped captures, saturating at 16'hFFFF
//                       cycle      clocks since reset/clr, saturating
//                       timeout    sticky, cycle reached TIMEOUT
//  Parameters  : DEPTH   - FIFO entries, power of 2 in 4..256
//                TIMEOUT - cycle count at which capture stops
//  Macro       : SR_TRACE_A0_EN - when defined, a0 is stored and returned on
//                rd_a0; otherwise there is no a0 storage and rd_a0 is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_trace_buf #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 160
) (
   input  wire logic        clk,
   input  wire logic        rst,
   sr_trace_buf_if.slave    bus
);

   localparam int                c_aw      = $clog2(DEPTH);
   localparam int                c_cw      = c_aw + 1;
   localparam logic [c_cw-1:0]   c_depth   = c_cw'(DEPTH);
   localparam logic [c_cw-1:0]   c_cnt_one = c_cw'(1);
   localparam logic [c_aw-1:0]   c_ptr_one = c_aw'(1);
   localparam logic [15:0]       c_timeout = 16'(TIMEOUT);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [c_aw-1:0]  wr_ptr_q,   wr_ptr_d;
   logic [c_aw-1:0]  rd_ptr_q,   rd_ptr_d;
   logic [c_cw-1:0]  count_q,    count_d;
   logic             overflow_q, overflow_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;
   logic [15:0]      cycle_q,    cycle_d;
   logic             timeout_q,  timeout_d;

   // Entry storage; intentionally not reset.
   logic [31:0]      pc_mem    [DEPTH];
   logic [31:0]      instr_mem [DEPTH];

   // -------------------------------------------------------------------------
   // Handshake decode
   // -------------------------------------------------------------------------
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_cap;
   logic             w_push;
   logic             w_drop;
   logic             w_mem_we;

   always_comb begin
      w_full   = (count_q == c_depth);
      w_empty  = (count_q == '0);
      // rd_ready while empty has no effect.
      w_pop    = !w_empty && bus.rd_ready;
      // Once timed out, capture requests are ignored entirely (no drops).
      w_cap    = bus.cap_en && !timeout_q;
      // A full FIFO still accepts a capture if the head leaves this cycle.
      w_push   = w_cap && (!w_full || w_pop);
      w_drop   = w_cap && w_full && !w_pop;
      w_mem_we = w_push && !bus.clr;
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      cycle_d    = cycle_q;
      timeout_d  = timeout_q;

      if (bus.clr) begin
         // clear dominates any push/pop presented in the same cycle
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         drop_cnt_d = '0;
         cycle_d    = '0;
         timeout_d  = 1'b0;
      end else begin
         // pointers wrap naturally: DEPTH is a power of two
         if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
         end
         if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
         end

         unique case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
         endcase

         if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
               drop_cnt_d = drop_cnt_q + 16'd1;
            end
         end

         if (cycle_q < c_timeout) begin
            cycle_d = cycle_q + 16'd1;
         end
         // Flag rises on the same edge the counter reaches TIMEOUT so the
         // capture window is exactly TIMEOUT clocks long.
         timeout_d = timeout_q || (cycle_d >= c_timeout);
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
         cycle_q    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
         cycle_q    <= cycle_d;
         timeout_q  <= timeout_d;
      end
   end

   // -------------------------------------------------------------------------
   // Entry storage
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         pc_mem[wr_ptr_q]    <= bus.pc;
         instr_mem[wr_ptr_q] <= bus.instr;
      end
   end

`ifdef SR_TRACE_A0_EN
   logic [31:0]      a0_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         a0_mem[wr_ptr_q] <= bus.a0;
      end
   end

   assign bus.rd_a0 = a0_mem[rd_ptr_q];
`else
   // a0 is not traced in this build; the input is deliberately dropped.
   logic             unused_a0;
   assign unused_a0 = ^bus.a0;
   assign bus.rd_a0 = 32'h0;
`endif

   // -------------------------------------------------------------------------
   // Outputs: head entry falls through combinationally from storage. An
   // empty FIFO never bypasses the input; rd_valid follows count.
   // -------------------------------------------------------------------------
   assign bus.rd_valid = !w_empty;
   assign bus.rd_pc    = pc_mem[rd_ptr_q];
   assign bus.rd_instr = instr_mem[rd_ptr_q];
   assign bus.count    = count_q;
   assign bus.overflow = overflow_q;
   assign bus.drop_cnt = drop_cnt_q;
   assign bus.cycle    = cycle_q;
   assign bus.timeout  = timeout_q;

endmodule
`default_nettype wire
